// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Optional macro RV_MC_MEM_TIMEOUT_EN adds a memory wait watchdog.
//
// Ports:
//   clk, rst_n      clock (rising), async active-low reset
//   start           leave IDLE and begin fetching
//   instr[31:0]     IR contents, valid from DECODE onward
//   mem_ready       memory handshake, completes access when high
//   br_taken        branch compare result, valid in EXEC
//   imm_sel[2:0]    immediate format (0=I 1=S 2=B 3=U 4=J 6=shamt 7=none)
//   ir_we, pc_we    IR load / PC update strobes
//   pc_src[1:0]     0=PC+4 1=PC+imm 2=ALU 3=reset vector
//   alu_src_b       0=rs2 1=immediate
//   reg_we          register file write enable
//   wb_sel[1:0]     0=ALU 1=memory 2=PC+4
//   mem_re, mem_we  memory read / write requests
//   busy            high outside IDLE
//   illegal         sticky trap flag
//   state_o[2:0]    current state encoding
module rv_mc_ctrl #(
    parameter int         MEM_TIMEOUT  = 16,
    parameter logic [1:0] RESET_PC_SEL = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic [2:0]  imm_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic        busy,
    output logic        illegal,
    output logic [2:0]  state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;
    localparam logic [2:0] S_RESET  = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] LP_TO_LAST = 5'(MEM_TIMEOUT - 1);

    logic [2:0] r_state;
    logic [2:0] r_imm_sel;
    logic [6:0] r_opc;
    logic       r_rd_zero;
    logic       r_illegal;

    logic [2:0] w_next;
    logic [2:0] w_dec_imm;
    logic       w_dec_ok;
    logic       w_ir_we;
    logic       w_pc_we;
    logic [1:0] w_pc_src;
    logic       w_alu_src_b;
    logic       w_reg_we;
    logic [1:0] w_wb_sel;
    logic       w_mem_re;
    logic       w_mem_we;
    logic       w_timeout;

    // Instruction class comes from the opcode latched in DECODE, so
    // later states do not depend on the IR staying stable.
    logic w_is_load;
    logic w_is_store;
    logic w_is_br;
    logic w_is_jal;
    logic w_is_jalr;
    logic w_is_reg;

    assign w_is_load  = (r_opc == OP_LOAD);
    assign w_is_store = (r_opc == OP_STORE);
    assign w_is_br    = (r_opc == OP_BRANCH);
    assign w_is_jal   = (r_opc == OP_JAL);
    assign w_is_jalr  = (r_opc == OP_JALR);
    assign w_is_reg   = (r_opc == OP_REG);

    always_comb begin
        w_dec_imm = 3'd7;
        w_dec_ok  = 1'b1;
        case (instr[6:0])
            OP_IMM: begin
                if (instr[13:12] == 2'b01)
                    w_dec_imm = 3'd6;
                else
                    w_dec_imm = 3'd0;
            end
            OP_LOAD,
            OP_JALR:   w_dec_imm = 3'd0;
            OP_STORE:  w_dec_imm = 3'd1;
            OP_BRANCH: w_dec_imm = 3'd2;
            OP_LUI,
            OP_AUIPC:  w_dec_imm = 3'd3;
            OP_JAL:    w_dec_imm = 3'd4;
            OP_REG:    w_dec_imm = 3'd7;
            default: begin
                w_dec_imm = 3'd7;
                w_dec_ok  = 1'b0;
            end
        endcase
    end

`ifdef RV_MC_MEM_TIMEOUT_EN
    logic [4:0] r_wait;
    logic       w_unused;

    assign w_timeout = !mem_ready && (r_wait == LP_TO_LAST);
    assign w_unused  = ^instr[31:15];

    // Clears on any state change, so each FETCH/MEM entry starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wait <= 5'd0;
        else if (w_next != r_state)
            r_wait <= 5'd0;
        else if (!mem_ready &&
                 (r_state == S_FETCH || r_state == S_MEM))
            r_wait <= r_wait + 5'd1;
    end
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign w_unused  = ^{instr[31:15], LP_TO_LAST};
`endif

    always_comb begin
        w_next      = r_state;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_src    = 2'd0;
        w_alu_src_b = 1'b0;
        w_reg_we    = 1'b0;
        w_wb_sel    = 2'd0;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            S_RESET: begin
                w_pc_we  = 1'b1;
                w_pc_src = RESET_PC_SEL;
                w_next   = S_IDLE;
            end
            S_IDLE: begin
                if (start)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                w_mem_re = 1'b1;
                if (mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                w_next = w_dec_ok ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                w_alu_src_b = !(w_is_reg || w_is_br);
                unique case (1'b1)
                    w_is_br: begin
                        w_pc_we  = br_taken;
                        w_pc_src = 2'd1;
                        w_next   = S_FETCH;
                    end
                    w_is_jal: begin
                        w_pc_we  = 1'b1;
                        w_pc_src = 2'd1;
                        w_next   = S_WB;
                    end
                    w_is_jalr: begin
                        w_pc_we  = 1'b1;
                        w_pc_src = 2'd2;
                        w_next   = S_WB;
                    end
                    (w_is_load || w_is_store): begin
                        w_next = S_MEM;
                    end
                    default: begin
                        w_next = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                w_mem_re = w_is_load;
                w_mem_we = !w_is_load;
                if (mem_ready)
                    w_next = w_is_load ? S_WB : S_FETCH;
                else if (w_timeout)
                    w_next = S_TRAP;
            end
            S_WB: begin
                w_reg_we = !r_rd_zero;
                if (w_is_load)
                    w_wb_sel = 2'd1;
                else if (w_is_jal || w_is_jalr)
                    w_wb_sel = 2'd2;
                w_next = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RESET;
            r_imm_sel <= 3'd7;
            r_opc     <= 7'd0;
            r_rd_zero <= 1'b1;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_imm_sel <= w_dec_imm;
                r_opc     <= instr[6:0];
                r_rd_zero <= (instr[11:7] == 5'd0);
            end
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

    // Strobes are gated by rst_n so a reset mid-access drops them
    // immediately, without waiting for a clock edge.
    assign imm_sel   = !rst_n ? 3'd7 :
                       (r_state == S_DECODE) ? w_dec_imm : r_imm_sel;
    assign ir_we     = rst_n & w_ir_we;
    assign pc_we     = rst_n & w_pc_we;
    assign pc_src    = rst_n ? w_pc_src : RESET_PC_SEL;
    assign alu_src_b = rst_n & w_alu_src_b;
    assign reg_we    = rst_n & w_reg_we;
    assign wb_sel    = rst_n ? w_wb_sel : 2'd0;
    assign mem_re    = rst_n & w_mem_re;
    assign mem_we    = rst_n & w_mem_we;
    assign busy      = rst_n & (r_state != S_IDLE);
    assign illegal   = r_illegal;
    assign state_o   = r_state;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb_rv_mc_ctrl: directed scoreboard bench for rv_mc_ctrl.
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_rv_mc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic [2:0]  imm_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        alu_src_b;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        mem_re;
    logic        mem_we;
    logic        busy;
    logic        illegal;
    logic [2:0]  state_o;

    rv_mc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .instr     (instr),
        .mem_ready (mem_ready),
        .br_taken  (br_taken),
        .imm_sel   (imm_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .alu_src_b (alu_src_b),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .busy      (busy),
        .illegal   (illegal),
        .state_o   (state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] imm;
        logic       ir;
        logic       pw;
        logic [1:0] ps;
        logic       ab;
        logic       rw;
        logic [1:0] wb;
        logic       mr;
        logic       mw;
        logic       busy;
        logic       ill;
    } vec_t;

    typedef struct {
        string nm;
        vec_t  v;
    } ent_t;

    ent_t q[$];
    ent_t mon_e;
    vec_t act;
    vec_t e;
    int   total;
    int   bad;

    assign act = {state_o, imm_sel, ir_we, pc_we, pc_src,
                  alu_src_b, reg_we, wb_sel, mem_re, mem_we,
                  busy, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic [2:0] st, input logic [2:0] im,
        input logic ir, input logic pw, input logic [1:0] ps,
        input logic ab, input logic rw, input logic [1:0] wb,
        input logic mr, input logic mw, input logic il);
        vec_t r;
        r.st   = st;
        r.imm  = im;
        r.ir   = ir;
        r.pw   = pw;
        r.ps   = ps;
        r.ab   = ab;
        r.rw   = rw;
        r.wb   = wb;
        r.mr   = mr;
        r.mw   = mw;
        r.busy = (st != 3'd0);
        r.ill  = il;
        return r;
    endfunction

    task automatic chk(input string nm, input vec_t a, input vec_t x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (st/imm/ir/pw/ps/ab/rw/wb/mr/mw/busy/ill)",
                     nm, a, x);
        end
    endtask

    task automatic cyc(input logic s, input logic rd, input logic bt,
                       input string nm, input vec_t x);
        start     = s;
        mem_ready = rd;
        br_taken  = bt;
        q.push_back('{nm, x});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk(mon_e.nm, act, mon_e.v);
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        instr     = 32'h0;
        mem_ready = 1'b0;
        br_taken  = 1'b0;
        @(posedge clk);
        #1;
        e = v(3'd7, 3'd7, 0, 0, 2'd3, 0, 0, 2'd0, 0, 0, 0);
        e.busy = 1'b0;
        chk("reset", act, e);
        rst_n = 1'b1;

        cyc(1, 1, 0, "rst_st",
            v(3'd7, 3'd7, 0, 1, 2'd3, 0, 0, 2'd0, 0, 0, 0));
        cyc(1, 1, 0, "idle",
            v(3'd0, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));

        // ADDI x1, x0, 5
        instr = 32'h00500093;
        cyc(1, 1, 0, "addi_f",
            v(3'd1, 3'd7, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(1, 1, 0, "addi_d",
            v(3'd2, 3'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(1, 1, 0, "addi_e",
            v(3'd3, 3'd0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "addi_w",
            v(3'd5, 3'd0, 0, 0, 2'd0, 0, 1, 2'd0, 0, 0, 0));

        // SW with three memory wait states
        instr = 32'h00112223;
        cyc(0, 1, 0, "sw_f",
            v(3'd1, 3'd0, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "sw_d",
            v(3'd2, 3'd1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "sw_e",
            v(3'd3, 3'd1, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, "sw_mwait",
                v(3'd4, 3'd1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 1, 0));
        cyc(0, 1, 0, "sw_mrdy",
            v(3'd4, 3'd1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 1, 0));

        // BEQ taken
        instr = 32'h00000463;
        cyc(0, 1, 0, "beq1_f",
            v(3'd1, 3'd1, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "beq1_d",
            v(3'd2, 3'd2, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 1, "beq1_e",
            v(3'd3, 3'd2, 0, 1, 2'd1, 0, 0, 2'd0, 0, 0, 0));

        // BEQ not taken
        cyc(0, 1, 0, "beq0_f",
            v(3'd1, 3'd2, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "beq0_d",
            v(3'd2, 3'd2, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "beq0_e",
            v(3'd3, 3'd2, 0, 0, 2'd1, 0, 0, 2'd0, 0, 0, 0));

        // SRLI
        instr = 32'h0020D093;
        cyc(0, 1, 0, "srli_f",
            v(3'd1, 3'd2, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "srli_d",
            v(3'd2, 3'd6, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "srli_e",
            v(3'd3, 3'd6, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "srli_w",
            v(3'd5, 3'd6, 0, 0, 2'd0, 0, 1, 2'd0, 0, 0, 0));

        // LUI
        instr = 32'h123450B7;
        cyc(0, 1, 0, "lui_f",
            v(3'd1, 3'd6, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "lui_d",
            v(3'd2, 3'd3, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "lui_e",
            v(3'd3, 3'd3, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "lui_w",
            v(3'd5, 3'd3, 0, 0, 2'd0, 0, 1, 2'd0, 0, 0, 0));

        // JAL
        instr = 32'h008000EF;
        cyc(0, 1, 0, "jal_f",
            v(3'd1, 3'd3, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "jal_d",
            v(3'd2, 3'd4, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "jal_e",
            v(3'd3, 3'd4, 0, 1, 2'd1, 1, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "jal_w",
            v(3'd5, 3'd4, 0, 0, 2'd0, 0, 1, 2'd2, 0, 0, 0));

        // LW x0: one fetch wait state, no register write
        instr = 32'h00002003;
        cyc(0, 0, 0, "lw_fwait",
            v(3'd1, 3'd4, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "lw_f",
            v(3'd1, 3'd4, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "lw_d",
            v(3'd2, 3'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "lw_e",
            v(3'd3, 3'd0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "lw_m",
            v(3'd4, 3'd0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "lw_w",
            v(3'd5, 3'd0, 0, 0, 2'd0, 0, 0, 2'd1, 0, 0, 0));

        // JALR x1, 0(x1)
        instr = 32'h000080E7;
        cyc(0, 1, 0, "jalr_f",
            v(3'd1, 3'd0, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "jalr_d",
            v(3'd2, 3'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "jalr_e",
            v(3'd3, 3'd0, 0, 1, 2'd2, 1, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "jalr_w",
            v(3'd5, 3'd0, 0, 0, 2'd0, 0, 1, 2'd2, 0, 0, 0));

        // Illegal opcode
        instr = 32'hFFFFFFFF;
        cyc(0, 1, 0, "ill_f",
            v(3'd1, 3'd0, 1, 1, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 1, 0, "ill_d",
            v(3'd2, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(1, 1, 0, "ill_trap",
            v(3'd6, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 1));
        cyc(1, 1, 0, "ill_hold",
            v(3'd6, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 1));

        start = 1'b0;
        rst_n = 1'b0;
        #1;
        e = v(3'd7, 3'd7, 0, 0, 2'd3, 0, 0, 2'd0, 0, 0, 0);
        e.busy = 1'b0;
        chk("trap_rst", act, e);
        #1;
        rst_n = 1'b1;
        cyc(0, 1, 0, "rst2_st",
            v(3'd7, 3'd7, 0, 1, 2'd3, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "rst2_idle",
            v(3'd0, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        cyc(0, 1, 0, "rst2_idle2",
            v(3'd0, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));

`ifdef RV_MC_MEM_TIMEOUT_EN
        cyc(1, 0, 0, "to_idle",
            v(3'd0, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, "to_wait",
                v(3'd1, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 0));
        cyc(0, 0, 0, "to_trap",
            v(3'd6, 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 1));
`endif

        @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
